// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage integer pipeline: operand forwarding,
// load-use and branch handling, multi-cycle multiply occupancy of EX, stall/flush counters.
module pipe_hazard_ctrl #(
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rs1,
    input  logic [4:0]       ex_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_branch_taken,
    input  logic             ex_mul_start,
    input  logic [4:0]       mem_rd,
    input  logic             mem_reg_write,
    input  logic [4:0]       wb_rd,
    input  logic             wb_reg_write,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_write,
    output logic             idex_bubble,
    output logic             exmem_bubble,
    output logic             mul_done,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic {StIdle, StBusy} state_e;

    localparam bit         MulMulti = (MUL_LAT >= 2);
    // First EX cycle is spent in IDLE, so BUSY counts down the remaining MUL_LAT-1 cycles.
    localparam logic [3:0] MulInit  = 4'(MUL_LAT - 2);

    state_e     state_q, state_d;
    logic [3:0] mul_cnt_q, mul_cnt_d;
    logic       mstall;
    logic       lu;

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == rs)) begin
            return 2'b01;
        end else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == rs)) begin
            return 2'b10;
        end
        return 2'b00;
    endfunction

    always_comb begin
        fwd_a_sel = fwd_sel(ex_rs1);
        fwd_b_sel = fwd_sel(ex_rs2);
    end

    always_comb begin
        lu = ex_mem_read && (ex_rd != 5'd0) &&
             ((id_use_rs1 && (ex_rd == id_rs1)) || (id_use_rs2 && (ex_rd == id_rs2)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            mul_cnt_q <= 4'd0;
        end else begin
            state_q   <= state_d;
            mul_cnt_q <= mul_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mul_cnt_d = mul_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (ex_mul_start && MulMulti) begin
                    state_d   = StBusy;
                    mul_cnt_d = MulInit;
                end
            end
            StBusy: begin
                if (mul_cnt_q != 4'd0) begin
                    mul_cnt_d = mul_cnt_q - 4'd1;
                end else begin
                    state_d = StIdle;
                end
            end
        endcase
    end

    always_comb begin
        mstall   = 1'b0;
        mul_done = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (ex_mul_start) begin
                    if (MulMulti) mstall = 1'b1;
                    else          mul_done = 1'b1;
                end
            end
            StBusy: begin
                if (mul_cnt_q != 4'd0) mstall = 1'b1;
                else                   mul_done = 1'b1;
            end
        endcase
        // A multiply stall must release as soon as reset rises, even with ex_mul_start held.
        if (rst) mstall = 1'b0;
    end

    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_write   = 1'b1;
        idex_bubble  = 1'b0;
        exmem_bubble = 1'b0;
        if (mstall) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_bubble = 1'b1;
        end else if (ex_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (lu) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (mstall || (lu && !ex_branch_taken)) stall_cnt <= stall_cnt + CNT_W'(1);
            if (ex_branch_taken && !mstall)         flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: default build plus a MUL_LAT=1 / CNT_W=4 build, both checked
// against a per-cycle reference model that tracks multiplies by elapsed EX cycles.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic       id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken, ex_mul_start;
    logic       mem_reg_write, wb_reg_write;

    logic [1:0]  fwd_a0, fwd_b0, fwd_a1, fwd_b1;
    logic        pc_write0, ifid_write0, ifid_flush0, idex_write0, idex_bubble0, exmem_bubble0;
    logic        pc_write1, ifid_write1, ifid_flush1, idex_write1, idex_bubble1, exmem_bubble1;
    logic        mul_done0, mul_done1;
    logic [31:0] stall_cnt0, flush_cnt0;
    logic [3:0]  stall_cnt1, flush_cnt1;
    logic [10:0] dv0, dv1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MUL_LAT(4), .CNT_W(32)) u_dut (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .ex_mul_start(ex_mul_start), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .fwd_a_sel(fwd_a0), .fwd_b_sel(fwd_b0),
        .pc_write(pc_write0), .ifid_write(ifid_write0), .ifid_flush(ifid_flush0),
        .idex_write(idex_write0), .idex_bubble(idex_bubble0), .exmem_bubble(exmem_bubble0),
        .mul_done(mul_done0), .stall_cnt(stall_cnt0), .flush_cnt(flush_cnt0)
    );

    pipe_hazard_ctrl #(.MUL_LAT(1), .CNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .ex_mul_start(ex_mul_start), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .fwd_a_sel(fwd_a1), .fwd_b_sel(fwd_b1),
        .pc_write(pc_write1), .ifid_write(ifid_write1), .ifid_flush(ifid_flush1),
        .idex_write(idex_write1), .idex_bubble(idex_bubble1), .exmem_bubble(exmem_bubble1),
        .mul_done(mul_done1), .stall_cnt(stall_cnt1), .flush_cnt(flush_cnt1)
    );

    assign dv0 = {fwd_a0, fwd_b0, pc_write0, ifid_write0, ifid_flush0, idex_write0,
                  idex_bubble0, exmem_bubble0, mul_done0};
    assign dv1 = {fwd_a1, fwd_b1, pc_write1, ifid_write1, ifid_flush1, idex_write1,
                  idex_bubble1, exmem_bubble1, mul_done1};

    // Reference model: a multiply is a run of MUL_LAT EX cycles; elapsed counts those done.
    int          lat_m[2]  = '{4, 1};
    logic [31:0] mask_m[2] = '{32'hFFFF_FFFF, 32'h0000_000F};
    bit          in_mul_m[2];
    int          elapsed_m[2];
    int          cur_m[2];
    bit          mst_m[2];
    logic [31:0] scnt_m[2], fcnt_m[2];
    logic [10:0] exp_v[2];
    bit          lu_m;

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (mem_reg_write && mem_rd != 0 && mem_rd == rs) return 2'b01;
        if (wb_reg_write && wb_rd != 0 && wb_rd == rs)    return 2'b10;
        return 2'b00;
    endfunction

    task automatic model_comb();
        bit pw, iw, ifl, xw, ib, eb, done;
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                in_mul_m[i] = 0; elapsed_m[i] = 0; scnt_m[i] = 0; fcnt_m[i] = 0;
            end
        end
        lu_m = ex_mem_read && ex_rd != 0 &&
               ((id_use_rs1 && ex_rd == id_rs1) || (id_use_rs2 && ex_rd == id_rs2));
        for (int i = 0; i < 2; i++) begin
            cur_m[i] = in_mul_m[i] ? elapsed_m[i] + 1 : (ex_mul_start ? 1 : 0);
            mst_m[i] = cur_m[i] != 0 && cur_m[i] < lat_m[i] && !rst;
            done     = cur_m[i] != 0 && cur_m[i] == lat_m[i];
            if (mst_m[i])             {pw, iw, ifl, xw, ib, eb} = 6'b000001;
            else if (ex_branch_taken) {pw, iw, ifl, xw, ib, eb} = 6'b111110;
            else if (lu_m)            {pw, iw, ifl, xw, ib, eb} = 6'b000110;
            else                      {pw, iw, ifl, xw, ib, eb} = 6'b110100;
            exp_v[i] = {ref_fwd(ex_rs1), ref_fwd(ex_rs2), pw, iw, ifl, xw, ib, eb, done};
        end
    endtask

    task automatic tick();
        model_comb();
        @(posedge clk);
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                if (cur_m[i] != 0 && cur_m[i] < lat_m[i]) begin
                    in_mul_m[i] = 1; elapsed_m[i] = cur_m[i];
                end else begin
                    in_mul_m[i] = 0; elapsed_m[i] = 0;
                end
                if (mst_m[i] || (lu_m && !ex_branch_taken))
                    scnt_m[i] = (scnt_m[i] + 1) & mask_m[i];
                if (ex_branch_taken && !mst_m[i])
                    fcnt_m[i] = (fcnt_m[i] + 1) & mask_m[i];
            end
        end
        @(negedge clk);
    endtask

    task automatic quiet();
        {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
        {id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken, ex_mul_start} = '0;
        {mem_reg_write, wb_reg_write} = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        quiet();
        ex_mul_start = 1'b1;
        #1;
        model_comb();
        total++;
        if (dv0 !== exp_v[0]) begin
            bad++; $display("FAIL reset_outputs got=%b exp=%b", dv0, exp_v[0]);
        end
        total++;
        if (stall_cnt0 !== 32'd0 || flush_cnt0 !== 32'd0) begin
            bad++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", stall_cnt0, flush_cnt0);
        end
        tick();
        rst = 1'b0;
        ex_mul_start = 1'b0;
        #1;
        total++;
        if (pc_write0 !== 1'b1 || exmem_bubble0 !== 1'b0 || stall_cnt0 !== 32'd0) begin
            bad++; $display("FAIL reset_release got pc=%b eb=%b sc=%0d exp pc=1 eb=0 sc=0",
                            pc_write0, exmem_bubble0, stall_cnt0);
        end
    endtask

    task automatic test_forwarding();
        quiet();
        mem_reg_write = 1; mem_rd = 5; wb_reg_write = 1; wb_rd = 5; ex_rs1 = 5; ex_rs2 = 0;
        #1;
        total++;
        if (fwd_a0 !== 2'b01 || fwd_b0 !== 2'b00) begin
            bad++; $display("FAIL fwd_exmem_prio got=%b/%b exp=01/00", fwd_a0, fwd_b0);
        end
        mem_rd = 0;
        #1;
        total++;
        if (fwd_a0 !== 2'b10) begin
            bad++; $display("FAIL fwd_memwb got=%b exp=10", fwd_a0);
        end
        wb_rd = 0;
        #1;
        total++;
        if (fwd_a0 !== 2'b00) begin
            bad++; $display("FAIL fwd_x0 got=%b exp=00", fwd_a0);
        end
        tick();
        for (int n = 0; n < 40; n++) begin
            ex_rs1 = 5'($urandom_range(0, 3)); ex_rs2 = 5'($urandom_range(0, 3));
            mem_rd = 5'($urandom_range(0, 3)); wb_rd = 5'($urandom_range(0, 3));
            mem_reg_write = 1'($urandom); wb_reg_write = 1'($urandom);
            #1;
            model_comb();
            total++;
            if (dv0 !== exp_v[0]) begin
                bad++; $display("FAIL fwd_random got=%b exp=%b", dv0, exp_v[0]);
            end
            tick();
        end
    endtask

    task automatic test_load_use();
        logic [31:0] s0;
        quiet();
        s0 = scnt_m[0];
        ex_mem_read = 1; ex_rd = 7; id_rs2 = 7; id_use_rs2 = 1;
        #1;
        total++;
        if (pc_write0 !== 0 || ifid_write0 !== 0 || idex_bubble0 !== 1 || idex_write0 !== 1) begin
            bad++; $display("FAIL lu_stall got pc=%b ifid=%b bub=%b idex=%b exp 0 0 1 1",
                            pc_write0, ifid_write0, idex_bubble0, idex_write0);
        end
        tick();
        ex_mem_read = 0;
        #1;
        total++;
        if (pc_write0 !== 1 || idex_bubble0 !== 0 || stall_cnt0 !== s0 + 1) begin
            bad++; $display("FAIL lu_one_cycle got pc=%b bub=%b sc=%0d exp pc=1 bub=0 sc=%0d",
                            pc_write0, idex_bubble0, stall_cnt0, s0 + 1);
        end
        ex_mem_read = 1; ex_rd = 0; id_rs2 = 0;
        #1;
        total++;
        if (pc_write0 !== 1 || idex_bubble0 !== 0) begin
            bad++; $display("FAIL lu_x0 got pc=%b bub=%b exp pc=1 bub=0", pc_write0, idex_bubble0);
        end
        ex_rd = 9; id_rs1 = 9; id_use_rs1 = 0;
        #1;
        total++;
        if (pc_write0 !== 1) begin
            bad++; $display("FAIL lu_unused_rs got pc=%b exp=1", pc_write0);
        end
        tick();
        total++;
        if (stall_cnt0 !== s0 + 1) begin
            bad++; $display("FAIL lu_no_count got=%0d exp=%0d", stall_cnt0, s0 + 1);
        end
    endtask

    task automatic test_branch();
        logic [31:0] s0, f0;
        quiet();
        s0 = scnt_m[0]; f0 = fcnt_m[0];
        ex_mem_read = 1; ex_rd = 3; id_rs1 = 3; id_use_rs1 = 1; ex_branch_taken = 1;
        #1;
        total++;
        if (ifid_flush0 !== 1 || idex_bubble0 !== 1 || pc_write0 !== 1) begin
            bad++; $display("FAIL branch_lu got fl=%b bub=%b pc=%b exp 1 1 1",
                            ifid_flush0, idex_bubble0, pc_write0);
        end
        tick();
        quiet();
        #1;
        total++;
        if (flush_cnt0 !== f0 + 1 || stall_cnt0 !== s0) begin
            bad++; $display("FAIL branch_counts got f=%0d s=%0d exp f=%0d s=%0d",
                            flush_cnt0, stall_cnt0, f0 + 1, s0);
        end
    endtask

    task automatic test_multiply();
        logic [31:0] s0, f0;
        bit stall;
        quiet();
        s0 = scnt_m[0]; f0 = fcnt_m[0];
        ex_mul_start = 1;
        // Held start: two back-to-back multiplies, stall pattern 1,1,1,done,1,1,1,done.
        for (int c = 1; c <= 8; c++) begin
            ex_branch_taken = (c == 2);
            #1;
            model_comb();
            stall = (c % 4) != 0;
            total++;
            if (exmem_bubble0 !== stall || idex_write0 !== !stall || mul_done0 !== !stall) begin
                bad++; $display("FAIL mul_cycle%0d got eb=%b idex=%b done=%b exp eb=%b",
                                c, exmem_bubble0, idex_write0, mul_done0, stall);
            end
            total++;
            if (dv1 !== exp_v[1]) begin
                bad++; $display("FAIL mul_lat1_cycle%0d got=%b exp=%b", c, dv1, exp_v[1]);
            end
            tick();
        end
        quiet();
        #1;
        total++;
        if (stall_cnt0 !== s0 + 6 || flush_cnt0 !== f0) begin
            bad++; $display("FAIL mul_counts got s=%0d f=%0d exp s=%0d f=%0d",
                            stall_cnt0, flush_cnt0, s0 + 6, f0);
        end
    endtask

    task automatic test_reset_mid_mul();
        quiet();
        ex_mul_start = 1;
        tick();
        #1;
        total++;
        if (exmem_bubble0 !== 1) begin
            bad++; $display("FAIL rmm_pre got eb=%b exp=1", exmem_bubble0);
        end
        #2 rst = 1;
        #1;
        total++;
        if (pc_write0 !== 1 || exmem_bubble0 !== 0 || stall_cnt0 !== 0 || flush_cnt0 !== 0) begin
            bad++; $display("FAIL rmm_async got pc=%b eb=%b s=%0d f=%0d exp 1 0 0 0",
                            pc_write0, exmem_bubble0, stall_cnt0, flush_cnt0);
        end
        tick();
        rst = 0;
        ex_mul_start = 0;
        #1;
        total++;
        if (pc_write0 !== 1 || exmem_bubble0 !== 0) begin
            bad++; $display("FAIL rmm_idle got pc=%b eb=%b exp 1 0", pc_write0, exmem_bubble0);
        end
        tick();
        ex_mul_start = 1;
        for (int c = 1; c <= 4; c++) begin
            #1;
            total++;
            if (mul_done0 !== (c == 4) || exmem_bubble0 !== (c != 4)) begin
                bad++; $display("FAIL rmm_restart%0d got done=%b eb=%b exp done=%b",
                                c, mul_done0, exmem_bubble0, c == 4);
            end
            tick();
        end
        quiet();
    endtask

    task automatic test_wrap();
        quiet();
        do_reset();
        ex_mem_read = 1; ex_rd = 4; id_rs1 = 4; id_use_rs1 = 1;
        for (int n = 0; n < 15; n++) tick();
        #1;
        total++;
        if (stall_cnt1 !== 4'd15) begin
            bad++; $display("FAIL wrap_max got=%0d exp=15", stall_cnt1);
        end
        tick();
        #1;
        total++;
        if (stall_cnt1 !== 4'd0 || stall_cnt0 !== 32'd16) begin
            bad++; $display("FAIL wrap_zero got=%0d/%0d exp=0/16", stall_cnt1, stall_cnt0);
        end
        quiet();
    endtask

    task automatic test_random();
        quiet();
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 63) == 0);
            id_rs1 = 5'($urandom_range(0, 7)); id_rs2 = 5'($urandom_range(0, 7));
            ex_rs1 = 5'($urandom_range(0, 7)); ex_rs2 = 5'($urandom_range(0, 7));
            ex_rd  = 5'($urandom_range(0, 7)); mem_rd = 5'($urandom_range(0, 7));
            wb_rd  = 5'($urandom_range(0, 7));
            {id_use_rs1, id_use_rs2, mem_reg_write, wb_reg_write} = 4'($urandom);
            ex_mem_read     = ($urandom_range(0, 2) == 0);
            ex_branch_taken = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 7) == 0) ex_mul_start = ~ex_mul_start;
            #1;
            model_comb();
            total++;
            if (dv0 !== exp_v[0] || dv1 !== exp_v[1]) begin
                bad++; $display("FAIL rand_outputs n=%0d got=%b/%b exp=%b/%b",
                                n, dv0, dv1, exp_v[0], exp_v[1]);
            end
            total++;
            if (stall_cnt0 !== scnt_m[0] || flush_cnt0 !== fcnt_m[0] ||
                stall_cnt1 !== scnt_m[1][3:0] || flush_cnt1 !== fcnt_m[1][3:0]) begin
                bad++; $display("FAIL rand_counters n=%0d got=%0d,%0d,%0d,%0d exp=%0d,%0d,%0d,%0d",
                                n, stall_cnt0, flush_cnt0, stall_cnt1, flush_cnt1,
                                scnt_m[0], fcnt_m[0], scnt_m[1][3:0], fcnt_m[1][3:0]);
            end
            tick();
        end
        rst = 0;
        quiet();
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch();
        test_multiply();
        test_reset_mid_mul();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage integer pipeline.
- Drives the forwarding selects of the two 3:1 ALU operand muxes.
- Drives the ID/EX control-bubble mux select and the PC/IF/ID/ID/EX write enables.
- Sequences multi-cycle multiply occupancy of EX with a small FSM.
- Keeps stall and flush performance counters.

Parameters:
MUL_LAT, 4, total EX cycles of a multiply (legal range 1..16)
CNT_W, 32, width of performance counters

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
id_rs1, id_rs2  in  5  source registers of the instruction in ID
id_use_rs1, id_use_rs2  in  1  ID instruction actually reads rs1/rs2
ex_rs1, ex_rs2  in  5  source registers of the instruction in EX
ex_rd  in  5  destination register in EX
ex_mem_read  in  1  EX instruction is a load
ex_branch_taken  in  1  EX resolved a taken branch or jump
ex_mul_start  in  1  EX holds a multiply (level; stays high while held)
mem_rd  in  5  destination register in MEM
mem_reg_write  in  1  MEM instruction writes the register file
wb_rd  in  5  destination register in WB
wb_reg_write  in  1  WB instruction writes the register file
fwd_a_sel, fwd_b_sel  out  2  00 = register file, 01 = EX/MEM, 10 = MEM/WB
pc_write  out  1  PC update enable
ifid_write  out  1  IF/ID register enable
ifid_flush  out  1  clear IF/ID to NOP
idex_write  out  1  ID/EX register enable
idex_bubble  out  1  zero the ID/EX control fields
exmem_bubble  out  1  insert a NOP into EX/MEM
mul_done  out  1  final EX cycle of a multiply
stall_cnt  out  CNT_W  cycles with any stall
flush_cnt  out  CNT_W  taken-branch flushes

Behaviour:
- Reset (async, rst=1):
  - FSM goes to IDLE; mul counter = 0; stall_cnt = 0; flush_cnt = 0.
  - Outputs then follow the combinational rules with the FSM in IDLE.
- Forwarding (combinational, per operand, shown for A using ex_rs1; B is identical using ex_rs2):
  - If mem_reg_write && mem_rd != 0 && mem_rd == ex_rs1: select 01.
  - Else if wb_reg_write && wb_rd != 0 && wb_rd == ex_rs1: select 10.
  - Else: select 00.
  - EX/MEM has priority over MEM/WB. Code 11 is never driven. x0 is never forwarded.
- Load-use hazard (lu):
  - lu = ex_mem_read && ex_rd != 0 && ((id_use_rs1 && ex_rd == id_rs1) || (id_use_rs2 && ex_rd == id_rs2)).
- Multiply FSM, states IDLE and BUSY, 4-bit counter:
  - IDLE, ex_mul_start=1, MUL_LAT ≥ 2: mstall=1; counter <= MUL_LAT-2; go to BUSY.
  - BUSY, counter != 0: mstall=1; counter decrements.
  - BUSY, counter == 0: mstall=0; mul_done=1; go to IDLE.
  - MUL_LAT = 1: the FSM stays in IDLE and mul_done = ex_mul_start.
  - ex_mul_start is ignored while in BUSY.
  - A multiply therefore stalls for exactly MUL_LAT-1 cycles.
  - Back-to-back multiplies: a new start is accepted in the IDLE cycle after mul_done.
- Output priority, highest first:
  1. mstall: pc_write=0, ifid_write=0, idex_write=0, exmem_bubble=1, idex_bubble=0, ifid_flush=0. lu and branch are ignored.
  2. ex_branch_taken: pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=1. Any lu in the same cycle is discarded.
  3. lu: pc_write=0, ifid_write=0, idex_write=1, idex_bubble=1. Lasts one cycle, because the load then leaves EX.
  4. Otherwise: all write enables = 1; all bubble/flush outputs = 0.
- Counters:
  - stall_cnt += 1 in every cycle where (mstall || (lu && !ex_branch_taken)).
  - flush_cnt += 1 in every cycle with ex_branch_taken && !mstall.
  - Both wrap modulo 2^CNT_W with no saturation.
- Reset mid-multiply: the FSM returns to IDLE immediately and all stall outputs deassert in the same cycle as rst rises.

Test Plan:
1. Forwarding: mem_reg_write=1, mem_rd=5, wb_reg_write=1, wb_rd=5, ex_rs1=5, ex_rs2=0 -> fwd_a_sel=01, fwd_b_sel=00. Then set mem_rd=0 -> fwd_a_sel=10.
2. Load-use: ex_mem_read=1, ex_rd=7, id_rs2=7, id_use_rs2=1 -> exactly 1 cycle with pc_write=0, ifid_write=0, idex_bubble=1; stall_cnt 0->1. Repeat with ex_rd=0 -> no stall.
3. Branch with simultaneous load-use -> ifid_flush=1, idex_bubble=1, pc_write=1; flush_cnt=1; stall_cnt unchanged.
4. Multiply, MUL_LAT=4, ex_mul_start held high -> 3 stall cycles (exmem_bubble=1, idex_write=0), then mul_done=1 in cycle 4; stall_cnt=3. A branch_taken pulse during the stall -> no flush and flush_cnt unchanged.
5. Assert rst in the 2nd stall cycle of a multiply -> pc_write=1, exmem_bubble=0, counters=0 asynchronously; the FSM is in IDLE after release.
6. Force stall_cnt to 2^CNT_W-1 (CNT_W=4 build), then one load-use stall -> stall_cnt wraps to 0.
